// File: rtl/ram_arbiter_2p_if.sv
// Two-port requester bundle for ram_arbiter_2p: per-port req/we/addr/wdata in, gnt/rvalid out, shared rdata/busy.
// master = requester side (CPU fetch/execute), slave = arbiter side.
interface ram_arbiter_2p_if;
   logic       req0;
   logic       we0;
   logic [3:0] addr0;
   logic [3:0] wdata0;
   logic       gnt0;
   logic       rvalid0;
   logic       req1;
   logic       we1;
   logic [3:0] addr1;
   logic [3:0] wdata1;
   logic       gnt1;
   logic       rvalid1;
   logic [3:0] rdata;
   logic       busy;

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      input  gnt0, rvalid0, gnt1, rvalid1, rdata, busy
   );

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      output gnt0, rvalid0, gnt1, rvalid1, rdata, busy
   );
endinterface

// File: rtl/ram_arbiter_2p.sv
// Shares one synchronous 16x4 RAM between fetch (port 0) and load/store (port 1); gnt 1 cycle after req, rvalid 2 after gnt.
// Requests are held until gnt; one access per 2 cycles under contention, round-robin or fixed priority.
module ram_arbiter_2p #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   ram_arbiter_2p_if.slave bus,
   output logic        mem_csn,
   output logic        mem_rwn,
   output logic [3:0]  mem_addr,
   output logic [3:0]  mem_datain,
   input  logic [3:0]  mem_dataout
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t     state, state_nx;
   logic       last, last_nx;
   logic       cur_port, cur_port_nx;
   logic       cur_we, cur_we_nx;
   logic       gnt0_q, gnt0_nx, gnt1_q, gnt1_nx;
   logic       rvalid0_q, rvalid0_nx, rvalid1_q, rvalid1_nx;
   logic [3:0] rdata_q, rdata_nx;
   logic       busy_q, busy_nx;
   logic       csn_nx, rwn_nx;
   logic [3:0] addr_nx, datain_nx;
   logic       any_req, pick1, arb_en;

   // last == 1 means port 1 was served most recently, so port 0 wins the next tie
   always_comb begin
      any_req = bus.req0 | bus.req1;
      if (FIXED_PRIO)
         pick1 = ~bus.req0 & bus.req1;
      else
         pick1 = bus.req1 & (~bus.req0 | ~last);
      arb_en = any_req & ((state == IDLE) | (state == DONE));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = any_req ? ISSUE : IDLE;
         ISSUE:   state_nx = DONE;
         DONE:    state_nx = any_req ? ISSUE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      gnt0_nx     = 1'b0;
      gnt1_nx     = 1'b0;
      rvalid0_nx  = 1'b0;
      rvalid1_nx  = 1'b0;
      rdata_nx    = rdata_q;
      csn_nx      = 1'b1;
      rwn_nx      = 1'b1;
      addr_nx     = mem_addr;
      datain_nx   = mem_datain;
      last_nx     = last;
      cur_port_nx = cur_port;
      cur_we_nx   = cur_we;
      busy_nx     = (state_nx != IDLE);
      // RAM output is registered, so read data is only valid in DONE
      if (state == DONE && !cur_we) begin
         rdata_nx   = mem_dataout;
         rvalid0_nx = ~cur_port;
         rvalid1_nx = cur_port;
      end
      if (arb_en) begin
         gnt0_nx     = ~pick1;
         gnt1_nx     = pick1;
         csn_nx      = 1'b0;
         rwn_nx      = pick1 ? ~bus.we1 : ~bus.we0;
         addr_nx     = pick1 ? bus.addr1 : bus.addr0;
         datain_nx   = pick1 ? bus.wdata1 : bus.wdata0;
         cur_we_nx   = pick1 ? bus.we1 : bus.we0;
         cur_port_nx = pick1;
         last_nx     = pick1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata_q    <= 4'h0;
         busy_q     <= 1'b0;
         mem_csn    <= 1'b1;
         mem_rwn    <= 1'b1;
         mem_addr   <= 4'h0;
         mem_datain <= 4'h0;
         last       <= 1'b1;
         cur_port   <= 1'b0;
         cur_we     <= 1'b0;
      end else begin
         gnt0_q     <= gnt0_nx;
         gnt1_q     <= gnt1_nx;
         rvalid0_q  <= rvalid0_nx;
         rvalid1_q  <= rvalid1_nx;
         rdata_q    <= rdata_nx;
         busy_q     <= busy_nx;
         mem_csn    <= csn_nx;
         mem_rwn    <= rwn_nx;
         mem_addr   <= addr_nx;
         mem_datain <= datain_nx;
         last       <= last_nx;
         cur_port   <= cur_port_nx;
         cur_we     <= cur_we_nx;
      end
   end

   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;
   assign bus.rdata   = rdata_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p: round-robin instance and fixed-priority instance, each with a 16x4 sync RAM model.
// RAM preloaded with mem[i] = 15 - i.
module tb_ram_arbiter_2p;
   logic clk;
   logic reset_n;
   logic ram_load;
   int   total;
   int   bad;

   ram_arbiter_2p_if ifa ();
   ram_arbiter_2p_if ifb ();

   logic       a_csn, a_rwn, b_csn, b_rwn;
   logic [3:0] a_addr, a_din, a_dout, b_addr, b_din, b_dout;
   logic [3:0] mem_a [16];
   logic [3:0] mem_b [16];

   ram_arbiter_2p #(.FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .reset_n(reset_n), .bus(ifa),
      .mem_csn(a_csn), .mem_rwn(a_rwn), .mem_addr(a_addr),
      .mem_datain(a_din), .mem_dataout(a_dout)
   );

   ram_arbiter_2p #(.FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .reset_n(reset_n), .bus(ifb),
      .mem_csn(b_csn), .mem_rwn(b_rwn), .mem_addr(b_addr),
      .mem_datain(b_din), .mem_dataout(b_dout)
   );

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 16; i++) begin
            mem_a[i] <= 4'(15 - i);
            mem_b[i] <= 4'(15 - i);
         end
      end else begin
         if (!a_csn) begin
            if (a_rwn) a_dout <= mem_a[a_addr];
            else       mem_a[a_addr] <= a_din;
         end
         if (!b_csn) begin
            if (b_rwn) b_dout <= mem_b[b_addr];
            else       mem_b[b_addr] <= b_din;
         end
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset_n  = 1'b0;
      ram_load = 1'b1;
      ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.addr0 = 4'h0; ifa.wdata0 = 4'h0;
      ifa.req1 = 1'b0; ifa.we1 = 1'b0; ifa.addr1 = 4'h0; ifa.wdata1 = 4'h0;
      ifb.req0 = 1'b0; ifb.we0 = 1'b0; ifb.addr0 = 4'h0; ifb.wdata0 = 4'h0;
      ifb.req1 = 1'b0; ifb.we1 = 1'b0; ifb.addr1 = 4'h0; ifb.wdata1 = 4'h0;

      // reset held with a pending request
      tick();
      tick();
      chk("rst_gnt0",    ifa.gnt0, 0);
      chk("rst_csn",     a_csn, 1);
      chk("rst_rwn",     a_rwn, 1);
      chk("rst_addr",    a_addr, 0);
      chk("rst_datain",  a_din, 0);
      chk("rst_busy",    ifa.busy, 0);
      chk("rst_rvalid0", ifa.rvalid0, 0);
      chk("rst_rdata",   ifa.rdata, 0);
      ifa.req0 = 1'b0;
      ram_load = 1'b0;
      reset_n  = 1'b1;
      tick();

      // round-robin contention: reads of 3 (0xC) and 7 (0x8)
      ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.addr0 = 4'd3;
      ifa.req1 = 1'b1; ifa.we1 = 1'b0; ifa.addr1 = 4'd7;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_gnt0", ifa.gnt0, (k % 4 == 0));
         chk("rr_gnt1", ifa.gnt1, (k % 4 == 2));
         chk("rr_both", ifa.gnt0 & ifa.gnt1, 0);
         chk("rr_rvalid0", ifa.rvalid0, (k % 4 == 2));
         chk("rr_rvalid1", ifa.rvalid1, (k >= 4 && k % 4 == 0));
         if (k == 2 || k == 6) chk("rr_rdata0", ifa.rdata, 8'hC);
         if (k == 4)           chk("rr_rdata1", ifa.rdata, 8'h8);
      end
      ifa.req0 = 1'b0;
      ifa.req1 = 1'b0;
      tick();
      chk("rr_last_rvalid1", ifa.rvalid1, 1);
      chk("rr_last_rdata",   ifa.rdata, 8'h8);
      tick();
      chk("rr_idle_busy", ifa.busy, 0);

      // port 0 write A to 5, then read it back
      ifa.req0 = 1'b1; ifa.we0 = 1'b1; ifa.addr0 = 4'd5; ifa.wdata0 = 4'hA;
      tick();
      chk("wr_gnt0",   ifa.gnt0, 1);
      chk("wr_csn",    a_csn, 0);
      chk("wr_rwn",    a_rwn, 0);
      chk("wr_addr",   a_addr, 5);
      chk("wr_datain", a_din, 8'hA);
      chk("wr_busy",   ifa.busy, 1);
      ifa.req0 = 1'b0;
      tick();
      chk("wr_gnt0_off", ifa.gnt0, 0);
      chk("wr_csn_off",  a_csn, 1);
      tick();
      chk("wr_no_rvalid", ifa.rvalid0, 0);
      chk("wr_busy_off",  ifa.busy, 0);
      ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.addr0 = 4'd5;
      tick();
      chk("rd_gnt0", ifa.gnt0, 1);
      chk("rd_csn",  a_csn, 0);
      chk("rd_rwn",  a_rwn, 1);
      ifa.req0 = 1'b0;
      tick();
      chk("rd_csn_off", a_csn, 1);
      chk("rd_early",   ifa.rvalid0, 0);
      tick();
      chk("rd_rvalid0", ifa.rvalid0, 1);
      chk("rd_rdata",   ifa.rdata, 8'hA);
      tick();
      chk("rd_rvalid0_off", ifa.rvalid0, 0);

      // back-to-back: port 1 writes F to 0, port 0 reads 0 without an IDLE gap
      ifa.req1 = 1'b1; ifa.we1 = 1'b1; ifa.addr1 = 4'd0; ifa.wdata1 = 4'hF;
      tick();
      chk("b2b_gnt1", ifa.gnt1, 1);
      ifa.req1 = 1'b0;
      ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.addr0 = 4'd0;
      tick();
      chk("b2b_gnt0_wait", ifa.gnt0, 0);
      tick();
      chk("b2b_gnt0",    ifa.gnt0, 1);
      chk("b2b_busy",    ifa.busy, 1);
      chk("b2b_csn",     a_csn, 0);
      chk("b2b_rvalid1", ifa.rvalid1, 0);
      ifa.req0 = 1'b0;
      tick();
      tick();
      chk("b2b_rvalid0", ifa.rvalid0, 1);
      chk("b2b_rdata",   ifa.rdata, 8'hF);

      // reset during ISSUE of a read
      ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.addr0 = 4'd5;
      tick();
      chk("mr_gnt0", ifa.gnt0, 1);
      ifa.req0 = 1'b0;
      reset_n  = 1'b0;
      #1;
      chk("mr_csn",  a_csn, 1);
      chk("mr_gnt0_off", ifa.gnt0, 0);
      chk("mr_busy", ifa.busy, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mr_no_rvalid", ifa.rvalid0, 0);
      end
      reset_n = 1'b1;
      ifa.req0 = 1'b1;
      tick();
      chk("mr_post_gnt0", ifa.gnt0, 1);
      ifa.req0 = 1'b0;
      tick();
      tick();
      chk("mr_post_rvalid0", ifa.rvalid0, 1);
      chk("mr_post_rdata",   ifa.rdata, 8'hA);

      // fixed priority: port 0 starves port 1 until req0 drops
      ifb.req0 = 1'b1; ifb.we0 = 1'b0; ifb.addr0 = 4'd2;
      ifb.req1 = 1'b1; ifb.we1 = 1'b0; ifb.addr1 = 4'd9;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("fp_gnt0", ifb.gnt0, (k % 2 == 0));
         chk("fp_gnt1", ifb.gnt1, 0);
         if (k == 2) chk("fp_rdata0", ifb.rdata, 8'hD);
      end
      ifb.req0 = 1'b0;
      tick();
      chk("fp_gnt1_on",  ifb.gnt1, 1);
      chk("fp_gnt0_off", ifb.gnt0, 0);
      chk("fp_rvalid0",  ifb.rvalid0, 1);
      ifb.req1 = 1'b0;
      tick();
      tick();
      chk("fp_rvalid1", ifb.rvalid1, 1);
      chk("fp_rdata1",  ifb.rdata, 8'h6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
